// File: rtl/div_ctrl.sv
// Sequencer between execute and an unsigned 64-bit multicycle divider: prepares magnitudes,
// resolves divide-by-zero and signed overflow locally, and applies sign/W-form fix-up.
module div_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_data,
  output logic             div_valid,
  output logic [63:0]      div_a,
  output logic [63:0]      div_b,
  input  logic             div_done,
  input  logic [127:0]     div_res,
  output logic [CNT_W-1:0] busy_cycles
);

  typedef enum logic [2:0] {IDLE, START, WAIT, RESP, DRAIN} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   neg_q, neg_r, rem_op, w_op;

  logic        accept, signed_op, w_in, rem_in;
  logic        sa, sb, b_zero, ovf;
  logic [63:0] a_ext, b_ext, mag_a, mag_b, spec_sel, spec_res;
  logic [63:0] q_fix, r_fix, fix_sel, fix_res;

  assign req_ready = (state == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign w_in      = req_op[2];
  assign rem_in    = req_op[1];
  assign signed_op = !req_op[0];

  always_comb begin
    if (w_in) begin
      a_ext = signed_op ? {{32{req_a[31]}}, req_a[31:0]} : {32'd0, req_a[31:0]};
      b_ext = signed_op ? {{32{req_b[31]}}, req_b[31:0]} : {32'd0, req_b[31:0]};
    end else begin
      a_ext = req_a;
      b_ext = req_b;
    end
    sa     = signed_op && a_ext[63];
    sb     = signed_op && b_ext[63];
    mag_a  = sa ? (~a_ext + 64'd1) : a_ext;
    mag_b  = sb ? (~b_ext + 64'd1) : b_ext;
    b_zero = (b_ext == 64'd0);
    // Most-negative dividend of the selected width over -1 would overflow the quotient.
    ovf    = signed_op && (b_ext == {64{1'b1}}) &&
             (a_ext == (w_in ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    if (b_zero) spec_sel = rem_in ? a_ext : {64{1'b1}};
    else        spec_sel = rem_in ? 64'd0 : a_ext;
    spec_res = w_in ? {{32{spec_sel[31]}}, spec_sel[31:0]} : spec_sel;
  end

  always_comb begin
    q_fix   = neg_q ? (~div_res[63:0] + 64'd1)   : div_res[63:0];
    r_fix   = neg_r ? (~div_res[127:64] + 64'd1) : div_res[127:64];
    fix_sel = rem_op ? r_fix : q_fix;
    fix_res = w_op ? {{32{fix_sel[31]}}, fix_sel[31:0]} : fix_sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      resp_valid  <= 1'b0;
      resp_data   <= 64'd0;
      div_valid   <= 1'b0;
      div_a       <= 64'd0;
      div_b       <= 64'd0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      rem_op      <= 1'b0;
      w_op        <= 1'b0;
      busy_cycles <= '0;
    end else begin
      if (state != IDLE && busy_cycles != {CNT_W{1'b1}})
        busy_cycles <= busy_cycles + CNT_ONE;
      case (state)
        IDLE: begin
          if (accept) begin
            if (b_zero || ovf) begin
              resp_data  <= spec_res;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              div_a     <= mag_a;
              div_b     <= mag_b;
              neg_q     <= sa ^ sb;
              neg_r     <= sa;
              rem_op    <= rem_in;
              w_op      <= w_in;
              div_valid <= 1'b1;
              state     <= START;
            end
          end
        end
        START: begin
          div_valid <= 1'b0;
          state     <= flush ? DRAIN : WAIT;
        end
        WAIT: begin
          if (div_done) begin
            if (flush) begin
              state <= IDLE;
            end else begin
              resp_data  <= fix_res;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        RESP: begin
          if (flush || resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        DRAIN: begin
          if (div_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
